fetch_module: RTL and testbench



---
 rtl/fetch_module.sv | 118 +++++++++++
 tb/tb_fetch_module.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_module.sv
// fetch_module: MIPS instruction-fetch stage (PC, instruction ROM, direct-mapped I-cache).
// Define FETCH_STATS_EN to add the hit_count/miss_count statistics outputs.
module fetch_module #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          IMEM_WORDS     = 1024,
  parameter int          CACHE_LINES    = 16,
  parameter int          LINE_WORDS     = 4,
  parameter int          MISS_LATENCY   = 4,
  parameter string       IMEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] branch_target,
  input  logic        pc_src,
  output logic [31:0] instruction,
  output logic [31:0] nextpc,
  output logic        hit
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(CACHE_LINES);
  localparam int TAG_W      = 30 - OFF_W - IDX_W;
  localparam int ROM_AW     = $clog2(IMEM_WORDS);
  localparam int DATA_WORDS = CACHE_LINES * LINE_WORDS;
  localparam int CNT_W      = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pc;
  logic [29:0]        pc_word;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   index;
  logic [OFF_W-1:0]   offset;
  logic [ROM_AW-OFF_W-1:0] line_rom_base;
  logic               fill_done;
  logic               unused_bits;

  logic [CACHE_LINES-1:0] valid;
  logic [TAG_W-1:0]       tag_store [CACHE_LINES];
  logic [31:0]            data_mem  [DATA_WORDS];
  logic [31:0]            rom       [IMEM_WORDS];

  // ROM contents: recognisable default pattern.
  generate
    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_word
      assign rom[i] = 32'h2000_0000 + 32'(i);
    end
  endgenerate

  assign pc_word       = pc[31:2];
  assign tag           = pc_word[29 -: TAG_W];
  assign index         = pc_word[OFF_W +: IDX_W];
  assign offset        = pc_word[OFF_W-1:0];
  assign line_rom_base = pc_word[ROM_AW-1:OFF_W];
  assign unused_bits   = ^branch_target[1:0];

  assign fill_done   = (state == FILL) && (cnt == CNT_W'(MISS_LATENCY - 1));
  assign hit         = (state == IDLE) && valid[index] && (tag_store[index] == tag);
  assign instruction = hit ? data_mem[{index, offset}] : 32'h0000_0000;
  assign nextpc      = pc + 32'd4;

  // PC and miss-handling control; the PC only advances on a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
    end else begin
      if (hit) pc <= pc_src ? {branch_target[31:2], 2'b00} : pc + 32'd4;
      case (state)
        IDLE: begin
          if (!hit) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        FILL: begin
          cnt <= cnt + CNT_W'(1);
          if (fill_done) begin
            valid[index] <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line fill: whole line copied in one edge; valid bit alone guards stale data.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_store[index] <= tag;
      for (int w = 0; w < LINE_WORDS; w++)
        data_mem[{index, OFF_W'(w)}] <= rom[{line_rom_base, OFF_W'(w)}];
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;
      if (state == IDLE && !hit) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_module.sv
// Directed bench for fetch_module: expected fetch results are queued per cycle and checked against the DUT.
module tb_fetch_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instruction, nextpc;
  logic        hit;
`ifdef FETCH_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic        h;
    logic [31:0] ins;
    logic [31:0] np;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  fetch_module dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_target (branch_target),
    .pc_src        (pc_src),
    .instruction   (instruction),
    .nextpc        (nextpc),
    .hit           (hit)
`ifdef FETCH_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic h, input logic [31:0] ins,
                          input logic [31:0] np);
    exp_t e;
    e.h = h; e.ins = ins; e.np = np;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic compare_front();
    exp_t  e;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    chk32({n, " hit"}, 32'(hit), 32'(e.h));
    chk32({n, " instr"}, instruction, e.ins);
    chk32({n, " nextpc"}, nextpc, e.np);
  endtask

  // One fetch cycle: queue what the stage must show, compare it, then clock.
  task automatic cyc(input string name, input logic h, input logic [31:0] ins,
                     input logic [31:0] np);
    push_exp(name, h, ins, np);
    compare_front();
    tick();
  endtask

  task automatic miss(input string name, input logic [31:0] np);
    for (int i = 0; i < 5; i++) cyc($sformatf("%s miss%0d", name, i), 1'b0, 32'h0, np);
  endtask

  initial begin
    tick();
    cyc("reset0", 1'b0, 32'h0, 32'h4);
    cyc("reset1", 1'b0, 32'h0, 32'h4);
    rst_n = 1'b1;

    miss("cold", 32'h4);
`ifdef FETCH_STATS_EN
    chk32("miss_count cold", miss_count, 32'd1);
    chk32("hit_count cold", hit_count, 32'd0);
`endif
    cyc("cold hit", 1'b1, 32'h2000_0000, 32'h4);
    cyc("seq 4", 1'b1, 32'h2000_0001, 32'h8);
    cyc("seq 8", 1'b1, 32'h2000_0002, 32'hC);
    cyc("seq C", 1'b1, 32'h2000_0003, 32'h10);
    miss("line1", 32'h14);

    pc_src = 1'b1;
    branch_target = 32'h0000_0042;
    cyc("pc10 hit", 1'b1, 32'h2000_0004, 32'h14);
    branch_target = 32'h0000_0100;   // changes while missing must not move the PC
    miss("br40", 32'h44);
    cyc("br40 hit", 1'b1, 32'h2000_0010, 32'h44);

    branch_target = 32'h0000_0000;
    miss("conf100", 32'h104);
    cyc("conf100 hit", 1'b1, 32'h2000_0040, 32'h104);
    miss("conf000", 32'h4);
    branch_target = 32'h0000_0080;
    cyc("refill0 hit", 1'b1, 32'h2000_0000, 32'h4);

    cyc("fill80 idle", 1'b0, 32'h0, 32'h84);
    cyc("fill80 cnt0", 1'b0, 32'h0, 32'h84);
    rst_n = 1'b0;
    #1;
    cyc("midreset", 1'b0, 32'h0, 32'h4);
`ifdef FETCH_STATS_EN
    chk32("hit_count reset", hit_count, 32'd0);
    chk32("miss_count reset", miss_count, 32'd0);
`endif
    rst_n = 1'b1;

    miss("after reset", 32'h4);
    cyc("after reset hit", 1'b1, 32'h2000_0000, 32'h4);
    miss("re80", 32'h84);
    branch_target = 32'hFFFF_FFFC;
    cyc("re80 hit", 1'b1, 32'h2000_0020, 32'h84);
    miss("wrap", 32'h0);
    pc_src = 1'b0;
    cyc("wrap hit", 1'b1, 32'h2000_03FF, 32'h0);
    cyc("wrapped pc0", 1'b1, 32'h2000_0000, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
